// File: rtl/rs_age_param.sv
// rtl/rs_age_param.sv - parametrised reservation station: wakeup, dense select, free-entry count
// Define RS_AGE_ISSUE_EN to build the age matrix and pick oldest-first instead of lowest-index.
module rs_age_param #(
    parameter int DEPTH   = 16,
    parameter int DISP_W  = 3,
    parameter int ISSUE_W = 3,
    parameter int CDB_W   = 3,
    parameter int PR_W    = 6,
    parameter int FU_N    = 4,
    parameter int PAY_W   = 96
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DISP_W-1:0]              disp_valid,
    input  logic [DISP_W*PR_W-1:0]         disp_src1_pr,
    input  logic [DISP_W*PR_W-1:0]         disp_src2_pr,
    input  logic [DISP_W-1:0]              disp_src1_rdy,
    input  logic [DISP_W-1:0]              disp_src2_rdy,
    input  logic [DISP_W*$clog2(FU_N)-1:0] disp_fu,
    input  logic [DISP_W*PAY_W-1:0]        disp_pay,
    output logic [DISP_W-1:0]              disp_stall,
    output logic [$clog2(DEPTH):0]         free_count,
    input  logic [CDB_W-1:0]               cdb_valid,
    input  logic [CDB_W*PR_W-1:0]          cdb_tag,
    input  logic [FU_N-1:0]                fu_stall,
    input  logic                           flush,
    output logic [ISSUE_W-1:0]             issue_valid,
    output logic [ISSUE_W*PAY_W-1:0]       issue_pay,
    output logic [ISSUE_W*PR_W-1:0]        issue_src1_pr,
    output logic [ISSUE_W*PR_W-1:0]        issue_src2_pr
);
    localparam int FU_W  = $clog2(FU_N);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_rdy1;
    logic [DEPTH-1:0] ent_rdy2;
    logic [PR_W-1:0]  ent_pr1 [DEPTH];
    logic [PR_W-1:0]  ent_pr2 [DEPTH];
    logic [FU_W-1:0]  ent_fu  [DEPTH];
    logic [PAY_W-1:0] ent_pay [DEPTH];

    logic [DEPTH-1:0]  wake1, wake2, req, issue_mask, alloc_mask;
    logic [DISP_W-1:0] alloc_ok;
    logic [IDX_W-1:0]  alloc_idx [DISP_W];
    logic [CNT_W-1:0]  n_issue, n_alloc;

`ifdef RS_AGE_ISSUE_EN
    logic [DEPTH-1:0] ent_age [DEPTH];
    logic [DEPTH-1:0] age_nxt [DEPTH];
    logic [DEPTH-1:0] lower_alloc;
`endif

    // Tag 0 is the zero register and is always ready; invalid broadcasts never match.
    function automatic logic woken(input logic [PR_W-1:0] tag,
                                   input logic [CDB_W-1:0] cv,
                                   input logic [CDB_W*PR_W-1:0] ct);
        logic hit;
        hit = (tag == '0);
        for (int m = 0; m < CDB_W; m++) begin
            if (cv[m] && (ct[m*PR_W +: PR_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        req   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = ent_rdy1[i] | woken(ent_pr1[i], cdb_valid, cdb_tag);
            wake2[i] = ent_rdy2[i] | woken(ent_pr2[i], cdb_valid, cdb_tag);
            req[i]   = ent_valid[i] & wake1[i] & wake2[i] & ~fu_stall[ent_fu[i]] & ~flush;
        end
    end

    // Cascaded picks; each pick excludes earlier winners so lanes fill densely from 0.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] win;
        issue_mask    = '0;
        issue_valid   = '0;
        issue_pay     = '0;
        issue_src1_pr = '0;
        issue_src2_pr = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            found = 1'b0;
            win   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && req[i] && !issue_mask[i]) begin
`ifdef RS_AGE_ISSUE_EN
                    if ((ent_age[i] & req & ~issue_mask) == '0) begin
                        found = 1'b1;
                        win   = IDX_W'(i);
                    end
`else
                    found = 1'b1;
                    win   = IDX_W'(i);
`endif
                end
            end
            if (found) begin
                issue_mask[win]                    = 1'b1;
                issue_valid[l]                     = 1'b1;
                issue_pay[l*PAY_W +: PAY_W]        = ent_pay[win];
                issue_src1_pr[l*PR_W +: PR_W]      = ent_pr1[win];
                issue_src2_pr[l*PR_W +: PR_W]      = ent_pr2[win];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            disp_stall[k] = (free_count <= CNT_W'(k));
        end
    end

    // Only entries invalid at the start of the cycle are allocatable, so issuing entries are never reused.
    always_comb begin
        alloc_mask = '0;
        alloc_ok   = '0;
        for (int k = 0; k < DISP_W; k++) begin
            alloc_idx[k] = '0;
            if (disp_valid[k] && !disp_stall[k] && !flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!alloc_ok[k] && !ent_valid[i] && !alloc_mask[i]) begin
                        alloc_ok[k]   = 1'b1;
                        alloc_idx[k]  = IDX_W'(i);
                        alloc_mask[i] = 1'b1;
                    end
                end
            end
        end
    end

`ifdef RS_AGE_ISSUE_EN
    // Columns of freed entries clear; a new row records everything older that stays resident.
    always_comb begin
        lower_alloc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_nxt[i] = ent_age[i] & ~issue_mask;
        end
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_ok[k]) begin
                age_nxt[alloc_idx[k]]   = (ent_valid & ~issue_mask) | lower_alloc;
                lower_alloc[alloc_idx[k]] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        n_issue = '0;
        n_alloc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_issue = n_issue + CNT_W'(issue_mask[i]);
            n_alloc = n_alloc + CNT_W'(alloc_mask[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_valid  <= '0;
            free_count <= CNT_W'(DEPTH);
`ifdef RS_AGE_ISSUE_EN
            for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
`endif
        end else if (flush) begin
            ent_valid  <= '0;
            free_count <= CNT_W'(DEPTH);
`ifdef RS_AGE_ISSUE_EN
            for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
`endif
        end else begin
            ent_valid  <= (ent_valid & ~issue_mask) | alloc_mask;
            free_count <= free_count + n_issue - n_alloc;
`ifdef RS_AGE_ISSUE_EN
            for (int i = 0; i < DEPTH; i++) ent_age[i] <= age_nxt[i];
`endif
        end
    end

    // Entry contents are qualified by ent_valid and need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                ent_rdy1[i] <= wake1[i];
                ent_rdy2[i] <= wake2[i];
            end
        end
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_ok[k]) begin
                ent_pr1[alloc_idx[k]]  <= disp_src1_pr[k*PR_W +: PR_W];
                ent_pr2[alloc_idx[k]]  <= disp_src2_pr[k*PR_W +: PR_W];
                ent_rdy1[alloc_idx[k]] <= disp_src1_rdy[k] |
                                          woken(disp_src1_pr[k*PR_W +: PR_W], cdb_valid, cdb_tag);
                ent_rdy2[alloc_idx[k]] <= disp_src2_rdy[k] |
                                          woken(disp_src2_pr[k*PR_W +: PR_W], cdb_valid, cdb_tag);
                ent_fu[alloc_idx[k]]   <= disp_fu[k*FU_W +: FU_W];
                ent_pay[alloc_idx[k]]  <= disp_pay[k*PAY_W +: PAY_W];
            end
        end
    end
endmodule
